// File: rtl/wb_retire_trace.sv
// Retire trace for the MEM/WB boundary: rebuilds each retired instruction's write-back,
// queues it in a small FIFO and streams it out over a valid/ready port, with halt drain.
module wb_retire_trace #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mw_reg_write,
    input  logic             mw_mem_to_reg,
    input  logic             mw_jump,
    input  logic [31:0]      mw_pc_four,
    input  logic [31:0]      mw_alu_result,
    input  logic [31:0]      mw_mem_read_data,
    input  logic [4:0]       mw_rd,
    input  logic [31:0]      mw_instr,
    input  logic             halt_i,
    output logic             tr_valid,
    input  logic             tr_ready,
    output logic [31:0]      tr_pc,
    output logic [31:0]      tr_instr,
    output logic [4:0]       tr_rd,
    output logic             tr_we,
    output logic [31:0]      tr_wdata,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow,
    output logic             done_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wdata;
    } rec_t;

    state_t state, state_next;
    rec_t   mem [DEPTH];
    rec_t   rec_in;
    rec_t   head;

    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full;
    logic        retire, pop, push_req, push, drop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign retire   = (mw_instr != '0);
    assign pop      = tr_valid && tr_ready;
    assign push_req = retire && (state == RUN);
    // A full FIFO still accepts the push when the head leaves on the same edge.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        rec_in       = '0;
        rec_in.pc    = mw_pc_four - 32'd4;
        rec_in.instr = mw_instr;
        rec_in.rd    = mw_rd;
        rec_in.we    = mw_reg_write && (mw_rd != 5'd0);
        if (rec_in.we) begin
            if (mw_jump)
                rec_in.wdata = mw_pc_four;
            else if (mw_mem_to_reg)
                rec_in.wdata = mw_mem_read_data;
            else
                rec_in.wdata = mw_alu_result;
        end
    end

    // Storage is cleared on reset so the head-driven outputs read zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= rec_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            retired_count <= '0;
            drop_count    <= '0;
            overflow      <= 1'b0;
            state         <= RUN;
        end else begin
            state <= state_next;
            if (push) begin
                wr_ptr        <= wr_ptr + 1'b1;
                retired_count <= retired_count + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (drop) begin
                drop_count <= drop_count + 1'b1;
                overflow   <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (retire && halt_i) state_next = DRAIN;
            DRAIN:   if (empty) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    assign head     = mem[rd_ptr[AW-1:0]];
    assign tr_valid = !empty;
    assign tr_pc    = head.pc;
    assign tr_instr = head.instr;
    assign tr_rd    = head.rd;
    assign tr_we    = head.we;
    assign tr_wdata = head.wdata;
    assign done_o   = (state == DONE);

endmodule

// File: tb/tb_wb_retire_trace.sv
// Randomised bench for wb_retire_trace: a queue-based trace model is updated on every
// clock edge and compared against the DUT outputs on every falling edge.
module tb_wb_retire_trace;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mw_reg_write = 1'b0, mw_mem_to_reg = 1'b0, mw_jump = 1'b0;
    logic [31:0] mw_pc_four = '0, mw_alu_result = '0, mw_mem_read_data = '0, mw_instr = '0;
    logic [4:0]  mw_rd = '0;
    logic        halt_i = 1'b0, tr_ready = 1'b0;
    logic        tr_valid, tr_we, overflow, done_o;
    logic [31:0] tr_pc, tr_instr, tr_wdata, retired_count, drop_count;
    logic [4:0]  tr_rd;

    wb_retire_trace #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .mw_reg_write(mw_reg_write), .mw_mem_to_reg(mw_mem_to_reg), .mw_jump(mw_jump),
        .mw_pc_four(mw_pc_four), .mw_alu_result(mw_alu_result),
        .mw_mem_read_data(mw_mem_read_data), .mw_rd(mw_rd), .mw_instr(mw_instr),
        .halt_i(halt_i), .tr_valid(tr_valid), .tr_ready(tr_ready),
        .tr_pc(tr_pc), .tr_instr(tr_instr), .tr_rd(tr_rd), .tr_we(tr_we),
        .tr_wdata(tr_wdata), .retired_count(retired_count), .drop_count(drop_count),
        .overflow(overflow), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wdata;
    } rec_t;

    rec_t        q[$];
    logic [31:0] m_ret, m_drop;
    bit          m_ovf, m_halted, m_done;
    int          checks = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic rec_t mk();
        rec_t r;
        r.pc    = mw_pc_four - 32'd4;
        r.instr = mw_instr;
        r.rd    = mw_rd;
        r.we    = mw_reg_write && mw_rd != 0;
        if (!r.we)        r.wdata = 0;
        else if (mw_jump) r.wdata = mw_pc_four;
        else              r.wdata = mw_mem_to_reg ? mw_mem_read_data : mw_alu_result;
        return r;
    endfunction

    task automatic model_clear();
        q.delete();
        m_ret = 0; m_drop = 0; m_ovf = 0; m_halted = 0; m_done = 0;
    endtask

    task automatic model_edge();
        int  sz   = q.size();
        bit  pop  = (sz != 0) && tr_ready;
        if (pop) void'(q.pop_front());
        if (!m_halted) begin
            if (mw_instr != 0) begin
                if (sz < DEPTH || pop) begin q.push_back(mk()); m_ret++; end
                else begin m_drop++; m_ovf = 1; end
                if (halt_i) m_halted = 1;
            end
        end else if (!m_done && sz == 0) begin
            m_done = 1;
        end
    endtask

    task automatic compare();
        chk("tr_valid", 32'(tr_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("tr_pc", tr_pc, q[0].pc);
            chk("tr_instr", tr_instr, q[0].instr);
            chk("tr_rd", 32'(tr_rd), 32'(q[0].rd));
            chk("tr_we", 32'(tr_we), 32'(q[0].we));
            chk("tr_wdata", tr_wdata, q[0].wdata);
        end
        chk("retired_count", retired_count, m_ret);
        chk("drop_count", drop_count, m_drop);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("done_o", 32'(done_o), 32'(m_done));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_clear(); else model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic set_in(input logic [31:0] instr, input logic [4:0] rd, input logic rw,
                          input logic m2r, input logic jmp, input logic [31:0] pcf,
                          input logic [31:0] alu, input logic [31:0] rdata, input logic halt);
        mw_instr = instr; mw_rd = rd; mw_reg_write = rw; mw_mem_to_reg = m2r;
        mw_jump = jmp; mw_pc_four = pcf; mw_alu_result = alu;
        mw_mem_read_data = rdata; halt_i = halt;
    endtask

    task automatic bubble();
        set_in(32'h0, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom, $urandom, $urandom, 1'($urandom));
    endtask

    task automatic rand_retire();
        logic [31:0] instr = $urandom;
        if (instr == 0) instr = 32'h13;
        set_in(instr, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
               $urandom, $urandom, $urandom, 1'b0);
    endtask

    task automatic drain_all();
        int guard = 0;
        tr_ready = 1'b1;
        bubble();
        while (tr_valid && guard < 4 * DEPTH) begin step(); guard++; end
        chk("drain_timeout", 32'(tr_valid), 32'd0);
    endtask

    initial begin
        int pops, guard;
        logic [31:0] drop_before;
        model_clear();
        step(); step();
        chk("reset_tr_valid", 32'(tr_valid), 32'd0);
        chk("reset_tr_wdata", tr_wdata, 32'd0);
        reset = 1'b0;
        step();

        // Three identical ALU retires, consumer always ready.
        tr_ready = 1'b1;
        set_in(32'h00500093, 5'd1, 1'b1, 1'b0, 1'b0, 32'h8, 32'd5, 32'h0, 1'b0);
        step();
        chk("alu_pc", tr_pc, 32'h4);
        chk("alu_we", 32'(tr_we), 32'd1);
        chk("alu_wdata", tr_wdata, 32'd5);
        step(); step();
        bubble();
        step(); step();
        chk("alu_retired", retired_count, 32'd3);

        // Load, jump, write to x0.
        set_in(32'h0000A083, 5'd1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h40, 32'hDEADBEEF, 1'b0);
        step();
        chk("load_wdata", tr_wdata, 32'hDEADBEEF);
        set_in(32'h010000EF, 5'd1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h99, 32'h77, 1'b0);
        step();
        chk("jump_wdata", tr_wdata, 32'h20);
        set_in(32'h00700013, 5'd0, 1'b1, 1'b0, 1'b0, 32'h24, 32'd7, 32'h0, 1'b0);
        step();
        chk("x0_we", 32'(tr_we), 32'd0);
        chk("x0_wdata", tr_wdata, 32'd0);
        drain_all();

        // Overflow: DEPTH+2 retires with the consumer stalled.
        tr_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin rand_retire(); step(); end
        chk("ovf_drops", drop_count, 32'd2);
        chk("ovf_flag", 32'(overflow), 32'd1);
        tr_ready = 1'b1;
        bubble();
        for (int i = 0; i < DEPTH - 1; i++) step();
        chk("ovf_last_valid", 32'(tr_valid), 32'd1);
        step();
        chk("ovf_empty", 32'(tr_valid), 32'd0);

        // Full FIFO: pop and push on the same edge.
        tr_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin rand_retire(); step(); end
        tr_ready = 1'b1;
        rand_retire();
        step();
        chk("full_pop_push_drops", drop_count, 32'd2);
        tr_ready = 1'b0;
        bubble();
        step();
        tr_ready = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) step();
        chk("full_still_depth", 32'(tr_valid), 32'd1);
        step();
        chk("full_empty", 32'(tr_valid), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) bubble(); else rand_retire();
            tr_ready = 1'($urandom_range(0, 9) < 6);
            step();
        end
        drain_all();

        // Halt with three queued, more retires after the halt.
        tr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin rand_retire(); step(); end
        rand_retire();
        halt_i = 1'b1;
        step();
        pops = 0; guard = 0;
        while (tr_valid && guard < 200) begin
            rand_retire();
            halt_i = 1'($urandom);
            tr_ready = 1'($urandom);
            if (tr_valid && tr_ready) pops++;
            step();
            guard++;
        end
        chk("halt_timeout", 32'(tr_valid), 32'd0);
        chk("halt_records", 32'(pops), 32'd4);
        chk("halt_done_not_yet", 32'(done_o), 32'd0);
        step();
        chk("halt_done", 32'(done_o), 32'd1);
        for (int i = 0; i < 10; i++) begin rand_retire(); tr_ready = 1'($urandom); step(); end
        chk("halt_done_held", 32'(done_o), 32'd1);

        // Asynchronous reset mid-drain with five queued.
        reset = 1'b1; step(); reset = 1'b0; step();
        tr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin rand_retire(); step(); end
        rand_retire();
        halt_i = 1'b1;
        step();
        rand_retire();
        step();
        chk("pre_reset_valid", 32'(tr_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        model_clear();
        chk("async_valid", 32'(tr_valid), 32'd0);
        chk("async_retired", retired_count, 32'd0);
        chk("async_drops", drop_count, 32'd0);
        chk("async_done", 32'(done_o), 32'd0);
        chk("async_pc", tr_pc, 32'd0);
        step();
        reset = 1'b0;
        bubble();
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/wb_retire_trace.md
Name: wb_retire_trace

Overview:
Reader at the far end of the MEM/WB pipeline register. Each cycle it samples the MEM/WB fields and reconstructs the retired instruction's write-back. It queues one commit record per non-bubble instruction in a small FIFO and streams the records out over a valid/ready trace port for debug capture and lockstep checking against a reference model. It also keeps retire and drop counters and performs a halt-drain sequence.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
CNT_W, 32, width of the retired_count and drop_count counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
mw_reg_write  in  1  MEM/WB RegWrite.
mw_mem_to_reg  in  1  MEM/WB MemtoReg.
mw_jump  in  1  MEM/WB Jump.
mw_pc_four  in  32  MEM/WB Pc_Four.
mw_alu_result  in  32  MEM/WB Alu_Result.
mw_mem_read_data  in  32  MEM/WB MemReadData.
mw_rd  in  5  MEM/WB destination register.
mw_instr  in  32  MEM/WB Curr_Instr.
halt_i  in  1  halt committed this cycle; qualified by a non-bubble mw_instr.
tr_valid  out  1  head record is valid.
tr_ready  in  1  consumer accepts the head record.
tr_pc  out  32  PC of the retired instruction.
tr_instr  out  32  retired instruction word.
tr_rd  out  5  destination register.
tr_we  out  1  register-file write occurred.
tr_wdata  out  32  write-back data.
retired_count  out  CNT_W  records pushed into the FIFO.
drop_count  out  CNT_W  records lost to a full FIFO.
overflow  out  1  sticky; set on the first drop.
done_o  out  1  halt drained.

Behaviour:
- Reset, asynchronous: FIFO empty, tr_valid=0, all tr_* data outputs 0, both counters 0, overflow=0, done_o=0, FSM=RUN. Reset asserted mid-stream discards all queued records immediately.
- Bubble: mw_instr==32'h0. Bubbles never push and never count. Any non-zero mw_instr is a retire.
- Record fields:
  - tr_pc = mw_pc_four - 4, modulo 2^32.
  - tr_instr = mw_instr.
  - tr_rd = mw_rd.
  - tr_we = mw_reg_write & (mw_rd != 0).
  - tr_wdata = mw_jump ? mw_pc_four : (mw_mem_to_reg ? mw_mem_read_data : mw_alu_result).
  - If tr_we=0, tr_wdata is forced to 0.
- Push:
  - Condition: retire is valid and FSM is RUN.
  - Latency: a record pushed at edge N is visible at the head at N+1 if the FIFO was empty.
  - tr_* outputs are registered and driven from the head entry.
- Pop handshake:
  - Pop occurs when tr_valid & tr_ready at the edge.
  - While tr_valid=1 and tr_ready=0, all tr_* outputs hold stable.
  - tr_valid never drops without a pop.
- Simultaneous push and pop:
  - When full, the push is accepted because the pop frees a slot in the same cycle.
  - When empty, no pass-through: tr_valid rises next cycle.
- Full without pop: the record is dropped, drop_count increments, overflow sets and stays set until reset. retired_count does not increment.
- Accepted push: retired_count increments.
- Counter wrap: both counters wrap modulo 2^CNT_W; no saturation.
- Pointer wrap: pointers are log2(DEPTH) bits plus a wrap bit. Full = indices equal and wrap bits differ.
- FSM:
  - RUN: a retire with halt_i=1 pushes its record (or drops it if full) and moves to DRAIN.
  - DRAIN: retire inputs are ignored (no push, no count); pops continue. Move to DONE on the cycle after the FIFO becomes empty.
  - DONE: done_o=1; inputs are ignored; held until reset.
- halt_i on a bubble is ignored.

Test Plan:
- Reset, then three ALU retires (instr 0x00500093, rd=1, alu=5, pc_four=0x8), tr_ready=1 -> three records in order; first has tr_pc=0x4, tr_we=1, tr_wdata=5; retired_count=3.
- Load with mem_to_reg=1, rdata=0xDEADBEEF; jump with pc_four=0x20, rd=1; write to rd=0 with reg_write=1 -> tr_wdata 0xDEADBEEF; then 0x20; then tr_we=0, tr_wdata=0.
- tr_ready=0, DEPTH+2 retires -> FIFO holds 8, drop_count=2, overflow=1; head outputs stable throughout; after releasing ready, exactly 8 records emerge in push order.
- Full FIFO with tr_ready=1 and a retire in the same cycle -> no drop; count stays at DEPTH.
- Halt retire with 3 queued, tr_ready toggling, further retires after the halt -> those retires are ignored; 4 records emerge; done_o=1 one cycle after empty and stays 1.
- Reset asserted asynchronously mid-drain with 5 queued -> tr_valid=0, counters 0, done_o=0 immediately, without waiting for a clock edge.
